// File: rtl/stream_rr_arbiter_if.sv
// Source-side and stream-side signals of stream_rr_arbiter; slave = arbiter, master = surrounding logic.
// ARB_STATS_EN adds the per-source grant counter bus.
interface stream_rr_arbiter_if #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_SRC    = 4
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_in;
  logic [NUM_SRC-1:0]            src_valid_in;
  logic [NUM_SRC-1:0]            src_ready_out;
  logic                          dst_ready_in;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          datavalid_out;
  logic [ID_W-1:0]               src_id_out;
  logic                          busy_out;
`ifdef ARB_STATS_EN
  logic [NUM_SRC*16-1:0]         grant_cnt_out;

  modport slave (
    input  src_data_in, src_valid_in, dst_ready_in,
    output src_ready_out, data_out, datavalid_out, src_id_out, busy_out, grant_cnt_out
  );
  modport master (
    output src_data_in, src_valid_in, dst_ready_in,
    input  src_ready_out, data_out, datavalid_out, src_id_out, busy_out, grant_cnt_out
  );
`else
  modport slave (
    input  src_data_in, src_valid_in, dst_ready_in,
    output src_ready_out, data_out, datavalid_out, src_id_out, busy_out
  );
  modport master (
    output src_data_in, src_valid_in, dst_ready_in,
    input  src_ready_out, data_out, datavalid_out, src_id_out, busy_out
  );
`endif
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter: NUM_SRC valid/ready sources onto one registered stream, 1-cycle latency;
// dst_ready_in low stalls the granted source. `ARB_STATS_EN adds saturating per-source word counters.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_SRC    = 4,
  parameter int BURST_LEN  = 4
) (
  input logic                clock,
  input logic                reset,
  stream_rr_arbiter_if.slave bus
);

  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [CW-1:0]         burst_q, burst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d;
  logic [IDW-1:0]        id_q, id_d;

  logic [IDW-1:0]        pick_idx;
  logic [IDW-1:0]        grant_nxt;
  logic                  gnt_vld;
  logic [DATA_WIDTH-1:0] gnt_word;
  logic [NUM_SRC-1:0]    src_rdy;
  logic                  xfer;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset back to ptr so the closest valid source wins.
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (bus.src_valid_in[rr_idx(ptr_q, k)]) pick_idx = rr_idx(ptr_q, k);
    end
  end

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_word = '0;
    src_rdy  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDW'(i)) begin
        gnt_vld  = bus.src_valid_in[i];
        gnt_word = bus.src_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      src_rdy[i] = (state_q == GRANT) && (grant_q == IDW'(i)) && bus.dst_ready_in;
    end
  end

  assign grant_nxt = (grant_q == IDW'(NUM_SRC - 1)) ? '0 : grant_q + IDW'(1);
  assign xfer      = (state_q == GRANT) && bus.dst_ready_in && gnt_vld;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    burst_d = burst_q;
    data_d  = data_q;
    id_d    = id_q;
    vld_d   = xfer;
    if (xfer) begin
      data_d = gnt_word;
      id_d   = grant_q;
    end
    case (state_q)
      IDLE: begin
        if (|bus.src_valid_in) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A source dropping valid releases the grant even while downstream stalls.
        if (!gnt_vld) begin
          state_d = IDLE;
          ptr_d   = grant_nxt;
        end else if (bus.dst_ready_in) begin
          burst_d = burst_q + CW'(1);
          if (burst_q == CW'(BURST_LEN - 1)) begin
            state_d = IDLE;
            ptr_d   = grant_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      burst_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

  assign bus.src_ready_out = src_rdy;
  assign bus.data_out      = data_q;
  assign bus.datavalid_out = vld_q;
  assign bus.src_id_out    = id_q;
  assign bus.busy_out      = (state_q == GRANT);

`ifdef ARB_STATS_EN
  logic [NUM_SRC-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer && (grant_q == IDW'(i)) && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.grant_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scenario bench for stream_rr_arbiter: per-source word queues feed the DUT, accepted words go to a scoreboard.
module tb_stream_rr_arbiter;

  localparam int DW = 12;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dst_rdy = 1'b1;

  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

  stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .BURST_LEN(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [DW-1:0] srcq [NS][$];
  logic [13:0]   exp_q [$];
  logic [13:0]   obs_q [$];
  logic          vld_log [$];
  logic [NS-1:0] rdy_log [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic bit srcs_empty();
    for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      bus.src_valid_in[i]          = (srcq[i].size() > 0);
      bus.src_data_in[i*DW +: DW]  = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
    bus.dst_ready_in = dst_rdy;
  endtask

  // One clock: record accepted words before the edge, record the stream after it.
  task automatic cycle();
    logic [NS-1:0] acc;
    #1;
    acc = bus.src_valid_in & bus.src_ready_out;
    rdy_log.push_back(bus.src_ready_out);
    for (int i = 0; i < NS; i++) begin
      if (acc[i] === 1'b1) begin
        if (!rst) exp_q.push_back({2'(i), srcq[i][0]});
        void'(srcq[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
    vld_log.push_back(bus.datavalid_out);
    if (bus.datavalid_out === 1'b1) obs_q.push_back({bus.src_id_out, bus.data_out});
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dst_rdy = 1'b1;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    drive();
    exp_q.delete();
    obs_q.delete();
    vld_log.delete();
    rdy_log.delete();
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 200 && !srcs_empty(); c++) cycle();
    repeat (3) cycle();
    n_cmp++;
    if (!srcs_empty()) begin
      n_err++;
      $display("FAIL %s drain: sources still holding words after cycle budget", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.datavalid_out !== 1'b0) begin n_err++; $display("FAIL reset datavalid_out: got %b want 0", bus.datavalid_out); end
    n_cmp++; if (bus.data_out !== 12'h000) begin n_err++; $display("FAIL reset data_out: got %h want 000", bus.data_out); end
    n_cmp++; if (bus.src_id_out !== 2'd0) begin n_err++; $display("FAIL reset src_id_out: got %0d want 0", bus.src_id_out); end
    n_cmp++; if (bus.busy_out !== 1'b0) begin n_err++; $display("FAIL reset busy_out: got %b want 0", bus.busy_out); end
    n_cmp++; if (bus.src_ready_out !== 4'b0000) begin n_err++; $display("FAIL reset src_ready_out: got %b want 0000", bus.src_ready_out); end
  endtask

  task automatic test_single_src();
    logic [8:0] pat;
    do_reset();
    for (int k = 0; k < 8; k++) srcq[2].push_back(12'h101 + 12'(k));
    drive();
    drain("single");
    pat = 9'b1111_0_1111;
    n_cmp++; if (vld_log[0] !== 1'b0) begin n_err++; $display("FAIL single arb bubble: datavalid %b want 0", vld_log[0]); end
    for (int n = 0; n < 9; n++) begin
      n_cmp++;
      if (vld_log[1+n] !== pat[8-n]) begin n_err++; $display("FAIL single vld pattern cycle %0d: got %b want %b", 1+n, vld_log[1+n], pat[8-n]); end
    end
    n_cmp++; if (obs_q.size() != 8) begin n_err++; $display("FAIL single word count: got %0d want 8", obs_q.size()); end
    for (int n = 0; n < obs_q.size() && n < 8; n++) begin
      n_cmp++;
      if (obs_q[n] !== {2'd2, 12'h101 + 12'(n)}) begin n_err++; $display("FAIL single word %0d: got %h want %h", n, obs_q[n], {2'd2, 12'h101 + 12'(n)}); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [13:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL single scoreboard: got %h want %h", o, e); end
    end
  endtask

  task automatic test_all_sources();
    int f;
    do_reset();
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < 8; k++) srcq[i].push_back(12'(16'h100 * i + k));
    drive();
    drain("all_src");
    n_cmp++; if (obs_q.size() != 32) begin n_err++; $display("FAIL all_src word count: got %0d want 32", obs_q.size()); end
    for (int n = 0; n < obs_q.size() && n < 32; n++) begin
      int b, s, w;
      b = n / 4; s = b % 4; w = 16'h100 * s + (b / 4) * 4 + (n % 4);
      n_cmp++;
      if (obs_q[n] !== {2'(s), 12'(w)}) begin n_err++; $display("FAIL all_src rr order word %0d: got %h want %h", n, obs_q[n], {2'(s), 12'(w)}); end
    end
    f = 0;
    while (f < vld_log.size() && vld_log[f] !== 1'b1) f++;
    for (int n = 0; n < 40; n++) begin
      n_cmp++;
      if (f + n >= vld_log.size()) begin n_err++; $display("FAIL all_src throughput: log ended at %0d want %0d", vld_log.size(), f + n); break; end
      if (vld_log[f+n] !== ((n % 5) != 4)) begin n_err++; $display("FAIL all_src throughput cycle %0d: got %b want %b", n, vld_log[f+n], ((n % 5) != 4)); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [13:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL all_src scoreboard: got %h want %h", o, e); end
    end
  endtask

  task automatic test_early_release();
    logic [13:0] want [6];
    logic [4:0]  pat;
    want = '{{2'd1, 12'h0A1}, {2'd1, 12'h0A2}, {2'd3, 12'h3B1}, {2'd3, 12'h3B2}, {2'd0, 12'h0C1}, {2'd0, 12'h0C2}};
    do_reset();
    srcq[1].push_back(12'h0A1);
    srcq[1].push_back(12'h0A2);
    drive();
    cycle();
    cycle();
    srcq[3].push_back(12'h3B1); srcq[3].push_back(12'h3B2);
    srcq[0].push_back(12'h0C1); srcq[0].push_back(12'h0C2);
    drive();
    drain("early");
    pat = 5'b11001;
    for (int n = 0; n < 5; n++) begin
      n_cmp++;
      if (vld_log[1+n] !== pat[4-n]) begin n_err++; $display("FAIL early release timing cycle %0d: got %b want %b", 1+n, vld_log[1+n], pat[4-n]); end
    end
    n_cmp++; if (obs_q.size() != 6) begin n_err++; $display("FAIL early word count: got %0d want 6", obs_q.size()); end
    for (int n = 0; n < obs_q.size() && n < 6; n++) begin
      n_cmp++;
      if (obs_q[n] !== want[n]) begin n_err++; $display("FAIL early grant order %0d: got %h want %h", n, obs_q[n], want[n]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [13:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL early scoreboard: got %h want %h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] pat;
    do_reset();
    for (int k = 0; k < 8; k++) srcq[0].push_back(12'h0C0 + 12'(k));
    for (int c = 0; c < 16; c++) begin
      if (c == 3) dst_rdy = 1'b0;
      if (c == 6) dst_rdy = 1'b1;
      drive();
      cycle();
    end
    n_cmp++; if (!srcs_empty()) begin n_err++; $display("FAIL stall words left: got %0d want 0", srcq[0].size()); end
    n_cmp++; if (rdy_log[1] !== 4'b0001) begin n_err++; $display("FAIL stall ready before stall: got %b want 0001", rdy_log[1]); end
    for (int c = 3; c < 6; c++) begin
      n_cmp++;
      if (rdy_log[c] !== 4'b0000) begin n_err++; $display("FAIL stall ready cycle %0d: got %b want 0000", c, rdy_log[c]); end
    end
    pat = 12'b1100_0110_1111;
    for (int n = 0; n < 12; n++) begin
      n_cmp++;
      if (vld_log[1+n] !== pat[11-n]) begin n_err++; $display("FAIL stall vld pattern cycle %0d: got %b want %b", 1+n, vld_log[1+n], pat[11-n]); end
    end
    n_cmp++; if (obs_q.size() != 8) begin n_err++; $display("FAIL stall word count: got %0d want 8", obs_q.size()); end
    for (int n = 0; n < obs_q.size() && n < 8; n++) begin
      n_cmp++;
      if (obs_q[n] !== {2'd0, 12'h0C0 + 12'(n)}) begin n_err++; $display("FAIL stall word %0d: got %h want %h", n, obs_q[n], {2'd0, 12'h0C0 + 12'(n)}); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 8; k++) srcq[1].push_back(12'h1E0 + 12'(k));
    drive();
    repeat (3) cycle();
    rst = 1'b1;
    srcq[0].push_back(12'h0D0);
    srcq[0].push_back(12'h0D1);
    drive();
    cycle();
    n_cmp++; if (bus.datavalid_out !== 1'b0) begin n_err++; $display("FAIL midrst datavalid_out: got %b want 0", bus.datavalid_out); end
    n_cmp++; if (bus.data_out !== 12'h000) begin n_err++; $display("FAIL midrst data_out: got %h want 000", bus.data_out); end
    n_cmp++; if (bus.src_id_out !== 2'd0) begin n_err++; $display("FAIL midrst src_id_out: got %0d want 0", bus.src_id_out); end
    n_cmp++; if (bus.busy_out !== 1'b0) begin n_err++; $display("FAIL midrst busy_out: got %b want 0", bus.busy_out); end
    rst = 1'b0;
    drive();
    drain("midrst");
    n_cmp++; if (obs_q.size() != 9) begin n_err++; $display("FAIL midrst word count: got %0d want 9", obs_q.size()); end
    n_cmp++; if (obs_q.size() > 2 && obs_q[2] !== {2'd0, 12'h0D0}) begin n_err++; $display("FAIL midrst first grant after reset: got %h want %h", obs_q[2], {2'd0, 12'h0D0}); end
    n_cmp++; if (obs_q.size() > 4 && obs_q[4] !== {2'd1, 12'h1E3}) begin n_err++; $display("FAIL midrst resumed word: got %h want %h", obs_q[4], {2'd1, 12'h1E3}); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [13:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL midrst scoreboard: got %h want %h", o, e); end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    n_cmp++; if (bus.grant_cnt_out !== 64'h0) begin n_err++; $display("FAIL stats reset: got %h want 0", bus.grant_cnt_out); end
    force dut.cnt_q = {16'hFFFE, 48'h0};
    @(negedge clk);
    release dut.cnt_q;
    for (int k = 0; k < 5; k++) srcq[3].push_back(12'h3F0 + 12'(k));
    drive();
    drain("stats");
    n_cmp++; if (bus.grant_cnt_out[63:48] !== 16'hFFFF) begin n_err++; $display("FAIL stats saturate: got %h want FFFF", bus.grant_cnt_out[63:48]); end
    n_cmp++; if (bus.grant_cnt_out[47:0] !== 48'h0) begin n_err++; $display("FAIL stats others: got %h want 0", bus.grant_cnt_out[47:0]); end
    n_cmp++; if (obs_q.size() != 5) begin n_err++; $display("FAIL stats word count: got %0d want 5", obs_q.size()); end
  endtask
`endif

  initial begin
    bus.src_valid_in = '0;
    bus.src_data_in  = '0;
    bus.dst_ready_in = 1'b1;
    test_reset();
    test_single_src();
    test_all_sources();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
